alu_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_addsub.sv | 31 +++
 rtl/alu_unit.sv | 82 ++++++++
 tb/tb_alu_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and default datapath width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH_DEFAULT = 32;
    localparam int unsigned ALU_CTRL_W        = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: a + b, or a - b via inverted b and carry-in of 1.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;

    // Conditional inversion of b, then one wide add with the sub flag as carry-in.
    always_comb begin
        b_eff   = b ^ {WIDTH{sub}};
        sum_ext = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
    end

    assign sum      = sum_ext[WIDTH-1:0];
    assign carry    = sum_ext[WIDTH];
    // Signed overflow: operands of equal sign producing a result of the other sign.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign negative = sum[WIDTH-1];

endmodule

// File: rtl/alu_unit.sv
// Integer ALU: combinational result/Zero plus a registered copy of both.
module alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      SrcA,
    input  logic [WIDTH-1:0]      SrcB,
    input  logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [WIDTH-1:0]      ALUResult,
    output logic                  Zero,
    output logic [WIDTH-1:0]      ALUResultQ,
    output logic                  ZeroQ
);

    logic             sub_c;
    logic [WIDTH-1:0] sum_c;
    logic             carry_c;
    logic             overflow_c;
    logic             negative_c;
    logic             slt_c;
    logic [WIDTH-1:0] result_c;
    logic             unused_carry;

    logic [WIDTH-1:0] alu_result_d, alu_result_q;
    logic             zero_d, zero_q;

    assign sub_c = (ALUControl == ALU_SUB) || (ALUControl == ALU_SLT);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a        (SrcA),
        .b        (SrcB),
        .sub      (sub_c),
        .sum      (sum_c),
        .carry    (carry_c),
        .overflow (overflow_c),
        .negative (negative_c)
    );

    // Carry out is architecturally discarded.
    assign unused_carry = carry_c;

    // Signed less-than: sign of the difference corrected for overflow.
    assign slt_c = negative_c ^ overflow_c;

    // Result select; undefined encodings produce zero.
    always_comb begin
        result_c = '0;
        case (ALUControl)
            ALU_ADD: result_c = sum_c;
            ALU_SUB: result_c = sum_c;
            ALU_AND: result_c = SrcA & SrcB;
            ALU_OR:  result_c = SrcA | SrcB;
            ALU_SLT: result_c = {{(WIDTH-1){1'b0}}, slt_c};
            default: result_c = '0;
        endcase
    end

    assign ALUResult    = result_c;
    assign Zero         = ~|result_c;
    assign alu_result_d = result_c;
    assign zero_d       = ~|result_c;

    // Registered copy; reset value matches a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q <= '0;
            zero_q       <= 1'b1;
        end else begin
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
        end
    end

    assign ALUResultQ = alu_result_q;
    assign ZeroQ      = zero_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: vector table plus registered-path scoreboard.
module tb_alu_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [31:0] ALUResultQ;
    logic        ZeroQ;

    alu_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .ALUResultQ (ALUResultQ),
        .ZeroQ      (ZeroQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] ctrl, input logic [31:0] res, input logic zero);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.ctrl = ctrl; v.res = res; v.zero = zero;
        vecs.push_back(v);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Pop the oldest expected registered value and compare against the Q outputs.
    task automatic check_registered(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", name, ALUResultQ);
        end else begin
            e = sb_q.pop_front();
            check32({name, " resq"}, ALUResultQ, e.res);
            check1({name, " zeroq"}, ZeroQ, e.zero);
        end
    endtask

    // Drive one vector at a falling edge, check combinational outputs, queue the expectation.
    task automatic apply_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        SrcA = v.a; SrcB = v.b; ALUControl = v.ctrl;
        #1;
        check32({v.name, " res"}, ALUResult, v.res);
        check1({v.name, " zero"}, Zero, v.zero);
        e.res = v.res; e.zero = v.zero;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_registered(v.name);
    endtask

    initial begin
        add_vec("add_basic",  32'h00001234, 32'h00005678, 3'b000, 32'h000068ac, 1'b0);
        add_vec("add_wrap",   32'hffffffff, 32'h00000001, 3'b000, 32'h00000000, 1'b1);
        add_vec("add_carry",  32'h80e0e0e0, 32'h80203040, 3'b000, 32'h01011120, 1'b0);
        add_vec("add_ovf",    32'h7fffffff, 32'h00000001, 3'b000, 32'h80000000, 1'b0);
        add_vec("sub_basic",  32'h00005678, 32'h00001234, 3'b001, 32'h00004444, 1'b0);
        add_vec("sub_equal",  32'h00001234, 32'h00001234, 3'b001, 32'h00000000, 1'b1);
        add_vec("sub_borrow", 32'h00000000, 32'h00000001, 3'b001, 32'hffffffff, 1'b0);
        add_vec("sub_ovf",    32'h7fffffff, 32'hffffffff, 3'b001, 32'h80000000, 1'b0);
        add_vec("and_zero",   32'ha5a5a5a5, 32'h5a5a5a5a, 3'b010, 32'h00000000, 1'b1);
        add_vec("and_mask",   32'hffffffff, 32'h01000010, 3'b010, 32'h01000010, 1'b0);
        add_vec("or_full",    32'hffff0000, 32'h0000ffff, 3'b011, 32'hffffffff, 1'b0);
        add_vec("or_mix",     32'h1c1c1c1c, 32'hc1c1c1c1, 3'b011, 32'hdddddddd, 1'b0);
        add_vec("slt_pos_lt", 32'h00000100, 32'h00000130, 3'b101, 32'h00000001, 1'b0);
        add_vec("slt_pos_ge", 32'h00000340, 32'h00000050, 3'b101, 32'h00000000, 1'b1);
        add_vec("slt_neg_lt", 32'hffffff33, 32'hffffffee, 3'b101, 32'h00000001, 1'b0);
        add_vec("slt_pn",     32'h12345678, 32'hfedcba98, 3'b101, 32'h00000000, 1'b1);
        add_vec("slt_maxmin", 32'h7fffffff, 32'h80000000, 3'b101, 32'h00000000, 1'b1);
        add_vec("slt_minmax", 32'h80000000, 32'h7fffffff, 3'b101, 32'h00000001, 1'b0);
        add_vec("slt_equal",  32'h00000005, 32'h00000005, 3'b101, 32'h00000000, 1'b1);
        add_vec("op_110",     32'h12341234, 32'habcdabcd, 3'b110, 32'h00000000, 1'b1);
        add_vec("op_100",     32'h12341234, 32'habcdabcd, 3'b100, 32'h00000000, 1'b1);
        add_vec("op_111",     32'h12341234, 32'habcdabcd, 3'b111, 32'h00000000, 1'b1);

        rst_n = 1'b0;
        SrcA = 32'h0; SrcB = 32'h0; ALUControl = 3'b000;
        @(posedge clk);
        #1;
        check32("reset resq", ALUResultQ, 32'h0);
        check1("reset zeroq", ZeroQ, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Load a nonzero registered value, then reset mid-cycle.
        apply_vec(vecs[10]);
        #2;
        rst_n = 1'b0;
        #1;
        check32("midrst resq", ALUResultQ, 32'h0);
        check1("midrst zeroq", ZeroQ, 1'b1);
        check32("midrst comb res", ALUResult, 32'hffffffff);
        check1("midrst comb zero", Zero, 1'b0);
        @(posedge clk);
        #1;
        check32("rst held resq", ALUResultQ, 32'h0);
        check1("rst held zeroq", ZeroQ, 1'b1);

        // Release and confirm one-cycle latency on the first transaction.
        @(negedge clk);
        rst_n = 1'b1;
        SrcA = 32'h00001234; SrcB = 32'h00005678; ALUControl = 3'b000;
        #1;
        check32("post rst comb res", ALUResult, 32'h000068ac);
        check1("post rst comb zero", Zero, 1'b0);
        check32("post rst pre-edge resq", ALUResultQ, 32'h0);
        check1("post rst pre-edge zeroq", ZeroQ, 1'b1);
        @(posedge clk);
        #1;
        check32("post rst resq", ALUResultQ, 32'h000068ac);
        check1("post rst zeroq", ZeroQ, 1'b0);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
